mem_port_scheduler: RTL and testbench

Shares the single memory-side port between `NUM_REQ` requesters, such as instruction fetch, load/store and a debug or refill agent. It uses round-robin selection and allows one transaction in flight at a time. It latches the winning request, drives it onto the memory port with a valid/ready handshake, waits for the response and routes it back to the owning requester. It sits between the core's memory clients and the memory or bus interface.

---
 rtl/mem_sched_pkg.sv | 26 ++
 rtl/mem_sched_rr_pick.sv | 35 +++
 rtl/mem_port_scheduler.sv | 169 ++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and defaults for the memory port scheduler.
// The latched request struct is sized by SCHED_ADDR_W/SCHED_DATA_W, so the top's ADDR_W/DATA_W must match them.
package mem_sched_pkg;

    localparam int SCHED_NUM_REQ = 4;
    localparam int SCHED_ADDR_W  = 32;
    localparam int SCHED_DATA_W  = 32;
    localparam int SCHED_IDX_W   = $clog2(SCHED_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                    we;
        logic [SCHED_ADDR_W-1:0] addr;
        logic [SCHED_DATA_W-1:0] wdata;
    } sched_req_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module mem_sched_rr_pick
    import mem_sched_pkg::*;
#(
    parameter int NUM_REQ = SCHED_NUM_REQ,
    parameter int IDX_W   = SCHED_IDX_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_o
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the nearest request overwrites earlier hits.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                winner_o = cand[IDX_W-1:0];
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters, one transaction in flight.
// Optional response watchdog enabled by defining MEM_SCHED_TIMEOUT_EN.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter  int NUM_REQ        = SCHED_NUM_REQ,
    parameter  int ADDR_W         = SCHED_ADDR_W,
    parameter  int DATA_W         = SCHED_DATA_W,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic                      mem_rsp_valid_i,
    input  logic [DATA_W-1:0]         mem_rsp_rdata_i,
    output logic                      busy_o,
    output logic [IDX_W-1:0]          owner_o
);

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    sched_req_t         reqLatch_q, reqLatch_d;
    logic [NUM_REQ-1:0] rspValid_q, rspValid_d;
    logic [DATA_W-1:0]  rspRdata_q, rspRdata_d;
    logic [IDX_W-1:0]   winner;
    logic               anyReq;
    logic               accept;
    logic               rspDone;
    logic               timeout;

    mem_sched_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req_valid_i),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (anyReq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (anyReq)                      state_d = ISSUE;
            ISSUE:    if (mem_req_ready_i)             state_d = WAIT_RSP;
            WAIT_RSP: if (mem_rsp_valid_i || timeout)  state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // The grant is masked during reset so every output reads zero while rst is high.
    always_comb begin
        req_ready_o = '0;
        accept      = 1'b0;
        rspDone     = 1'b0;
        if (state_q == IDLE && anyReq && !rst) begin
            req_ready_o[winner] = 1'b1;
            accept              = 1'b1;
        end
        if (state_q == WAIT_RSP && (mem_rsp_valid_i || timeout)) begin
            rspDone = 1'b1;
        end
        mem_req_valid_o = (state_q == ISSUE);
        busy_o          = (state_q != IDLE);
    end

    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        reqLatch_d = reqLatch_q;
        rspValid_d = '0;
        rspRdata_d = rspRdata_q;
        if (accept) begin
            owner_d          = winner;
            ptr_d            = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            reqLatch_d.we    = req_we_i[winner];
            reqLatch_d.addr  = req_addr_i[winner*ADDR_W +: ADDR_W];
            reqLatch_d.wdata = req_wdata_i[winner*DATA_W +: DATA_W];
        end
        if (rspDone) begin
            rspValid_d[owner_q] = 1'b1;
            rspRdata_d          = mem_rsp_valid_i ? mem_rsp_rdata_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            reqLatch_q <= '0;
            rspValid_q <= '0;
            rspRdata_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            reqLatch_q <= reqLatch_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
        end
    end

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rspErr_q, rspErr_d;

    // Timer idles at zero outside WAIT_RSP, so it starts from zero on every entry.
    always_comb begin
        timer_d  = '0;
        rspErr_d = rspErr_q;
        if (state_q == WAIT_RSP) begin
            timer_d = timer_q + 1'b1;
        end
        if (rspDone) begin
            rspErr_d = !mem_rsp_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            rspErr_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            rspErr_q <= rspErr_d;
        end
    end

    assign timeout   = (state_q == WAIT_RSP) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err_o = rspErr_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign rsp_err_o          = 1'b0;
`endif

    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;
    assign mem_we_o    = reqLatch_q.we;
    assign mem_addr_o  = reqLatch_q.addr;
    assign mem_wdata_o = reqLatch_q.wdata;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Bench for mem_port_scheduler: a vector table, directed corner cases and a random run
// checked against a transaction-level round-robin model.
module tb_mem_port_scheduler;
    import mem_sched_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = SCHED_IDX_W;

    typedef struct {
        logic [N-1:0]  rv;
        logic          mready;
        logic          mrsp;
        logic [DW-1:0] mdata;
        logic [N-1:0]  eReady;
        logic          eMv;
        logic          eBusy;
        logic [IW-1:0] eOwner;
        logic [N-1:0]  eRsp;
        logic [DW-1:0] eData;
        logic [AW-1:0] eAddr;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    reqValid, reqReady, reqWe, rspValid;
    logic [N*AW-1:0] reqAddr;
    logic [N*DW-1:0] reqWdata;
    logic [DW-1:0]   rspRdata, memWdata, memRspRdata;
    logic [AW-1:0]   memAddr;
    logic            rspErr, memReqValid, memReqReady, memWe, memRspValid, busy;
    logic [IW-1:0]   owner;

    int   compared   = 0;
    int   mismatched = 0;
    int   mptr       = 0;
    int   waits[N];
    vec_t vecs[13];

    mem_port_scheduler #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_we_i        (reqWe),
        .req_addr_i      (reqAddr),
        .req_wdata_i     (reqWdata),
        .rsp_valid_o     (rspValid),
        .rsp_rdata_o     (rspRdata),
        .rsp_err_o       (rspErr),
        .mem_req_valid_o (memReqValid),
        .mem_req_ready_i (memReqReady),
        .mem_we_o        (memWe),
        .mem_addr_o      (memAddr),
        .mem_wdata_o     (memWdata),
        .mem_rsp_valid_i (memRspValid),
        .mem_rsp_rdata_i (memRspRdata),
        .busy_o          (busy),
        .owner_o         (owner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic we,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        reqValid[i]           = v;
        reqWe[i]              = we;
        reqAddr[i*AW +: AW]   = a;
        reqWdata[i*DW +: DW]  = d;
    endtask

    function automatic int modelPick(input logic [N-1:0] pend, input int p);
        for (int k = 0; k < N; k++) begin
            if (pend[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Holds reset for two cycles with every input high and checks all outputs are zero; rst stays high on return.
    task automatic doReset();
        rst         = 1'b1;
        reqValid    = '1;
        reqWe       = '1;
        reqAddr     = '1;
        reqWdata    = '1;
        memReqReady = 1'b1;
        memRspValid = 1'b1;
        memRspRdata = '1;
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rstReqReady", reqReady, 0);
        checkOutput("rstRspValid", rspValid, 0);
        checkOutput("rstRspRdata", rspRdata, 0);
        checkOutput("rstRspErr", rspErr, 0);
        checkOutput("rstMemValid", memReqValid, 0);
        checkOutput("rstMemAddr", {memWe, memAddr}, 0);
        checkOutput("rstMemWdata", memWdata, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstOwner", owner, 0);
        mptr = 0;
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    task automatic releaseReset();
        nextCycle();
        rst         = 1'b0;
        reqValid    = '0;
        memReqReady = 1'b0;
        memRspValid = 1'b0;
        memRspRdata = '0;
    endtask

    // Runs one full transaction starting in an IDLE cycle whose inputs are already settled.
    task automatic doTxn(input int w, input logic [DW-1:0] rdata, input int stall, input int lat);
        logic [N-1:0]  oneHot;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic          expWe;
        oneHot    = '0;
        oneHot[w] = 1'b1;
        expAddr   = reqAddr[w*AW +: AW];
        expWdata  = reqWdata[w*DW +: DW];
        expWe     = reqWe[w];
        checkOutput("grant", reqReady, oneHot);
        mptr = (w + 1) % N;
        nextCycle();
        applyStimulus(w, 1'b0, ~expWe, $urandom, $urandom);
        memReqReady = (stall == 0);
        memRspValid = 1'b1;
        memRspRdata = 32'hBAD0_0000;
        #1;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                nextCycle();
                memReqReady = (s == stall);
                #1;
            end
            checkOutput("issueValid", memReqValid, 1);
            checkOutput("issueAddr", memAddr, expAddr);
            checkOutput("issueWdata", memWdata, expWdata);
            checkOutput("issueWe", memWe, expWe);
            checkOutput("issueReqReady", reqReady, 0);
            checkOutput("issueOwner", owner, w);
        end
        for (int l = 0; l <= lat; l++) begin
            nextCycle();
            memReqReady = 1'b0;
            memRspValid = (l == lat);
            memRspRdata = (l == lat) ? rdata : 32'hBAD0_0001;
            #1;
            checkOutput("waitBusy", busy, 1);
            checkOutput("waitMemValid", memReqValid, 0);
            checkOutput("waitRspValid", rspValid, 0);
        end
        nextCycle();
        memRspValid = 1'b0;
        #1;
        checkOutput("rspValid", rspValid, oneHot);
        checkOutput("rspRdata", rspRdata, rdata);
        checkOutput("rspErr", rspErr, 0);
        checkOutput("rspBusy", busy, 0);
    endtask

    task automatic buildTable();
        for (int r = 0; r < 13; r++) begin
            int k  = r / 3;
            int ph = r % 3;
            vecs[r].rv     = '1;
            vecs[r].mready = 1'b1;
            vecs[r].mrsp   = (ph == 2);
            vecs[r].mdata  = 32'hA000_0000 + k;
            vecs[r].eReady = (ph == 0) ? N'(1 << (k % N)) : '0;
            vecs[r].eMv    = (ph == 1);
            vecs[r].eBusy  = (ph != 0);
            vecs[r].eOwner = (ph == 0) ? IW'((k == 0) ? 0 : (k - 1) % N) : IW'(k % N);
            vecs[r].eRsp   = (ph == 0 && k > 0) ? N'(1 << ((k - 1) % N)) : '0;
            vecs[r].eData  = 32'hA000_0000 + k - 1;
            vecs[r].eAddr  = 32'h1000 + 16 * (k % N);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;

        // Table: all four requesters valid, memory always ready, one-cycle response.
        doReset();
        releaseReset();
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, i[0], 32'h1000 + 16 * i, 32'h5000 + i);
        buildTable();
        for (int r = 0; r < 13; r++) begin
            if (r > 0) nextCycle();
            reqValid    = vecs[r].rv;
            memReqReady = vecs[r].mready;
            memRspValid = vecs[r].mrsp;
            memRspRdata = vecs[r].mdata;
            #1;
            checkOutput($sformatf("tblReady%0d", r), reqReady, vecs[r].eReady);
            checkOutput($sformatf("tblMemValid%0d", r), memReqValid, vecs[r].eMv);
            checkOutput($sformatf("tblBusy%0d", r), busy, vecs[r].eBusy);
            checkOutput($sformatf("tblOwner%0d", r), owner, vecs[r].eOwner);
            checkOutput($sformatf("tblRsp%0d", r), rspValid, vecs[r].eRsp);
            if (vecs[r].eRsp != 0) checkOutput($sformatf("tblData%0d", r), rspRdata, vecs[r].eData);
            if (vecs[r].eMv) checkOutput($sformatf("tblAddr%0d", r), memAddr, vecs[r].eAddr);
        end

        // Pointer wrap: grant 1 leaves ptr at 2, so 3 beats 1, then ptr wraps to 0 and 1 wins.
        doReset();
        releaseReset();
        applyStimulus(1, 1'b1, 1'b0, 32'h2000, 32'h0);
        #1;
        doTxn(1, 32'h0000_0011, 0, 0);
        applyStimulus(1, 1'b1, 1'b1, 32'h2004, 32'h0000_00AA);
        applyStimulus(3, 1'b1, 1'b0, 32'h300C, 32'h0000_00BB);
        #1;
        doTxn(3, 32'h0000_0033, 0, 0);
        doTxn(1, 32'h0000_0022, 0, 1);

        // Requester 2 reads 0x100 under a 5-cycle memory stall while requester 0 waits.
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678);
        applyStimulus(2, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        doTxn(2, 32'hDEAD_BEEF, 5, 0);
        reqValid[0] = 1'b0;
        nextCycle();
        #1;
        checkOutput("singlePulse", rspValid, 0);
        checkOutput("dropNoGrant", busy, 0);

        // Reset in WAIT_RSP abandons the transaction without a response.
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        #1;
        checkOutput("midGrant", reqReady, 4'b0010);
        nextCycle();
        reqValid    = '0;
        memReqReady = 1'b1;
        nextCycle();
        memReqReady = 1'b0;
        rst         = 1'b1;
        memRspValid = 1'b1;
        memRspRdata = 32'h5555_5555;
        nextCycle();
        rst         = 1'b0;
        memRspValid = 1'b0;
        #1;
        checkOutput("midRstRsp", rspValid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstOwner", owner, 0);

        // Random traffic against the round-robin model, with stalls, latency and spurious responses.
        doReset();
        releaseReset();
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!reqValid[i] && $urandom_range(0, 1) == 1)
                    applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            if (reqValid == '0) applyStimulus(t % N, 1'b1, 1'b0, $urandom, $urandom);
            #1;
            w = modelPick(reqValid, mptr);
            for (int i = 0; i < N; i++) begin
                if (reqValid[i] && i != w) waits[i]++;
            end
            checkOutput("fairness", (waits[w] < N), 1);
            waits[w] = 0;
            doTxn(w, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef MEM_SCHED_TIMEOUT_EN
        // Watchdog: no response for 8 WAIT_RSP cycles yields an error pulse; a late response is ignored.
        doReset();
        releaseReset();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        #1;
        checkOutput("toGrant", reqReady, 4'b0001);
        nextCycle();
        reqValid    = '0;
        memReqReady = 1'b1;
        #1;
        checkOutput("toIssue", memReqValid, 1);
        for (int c = 0; c < 8; c++) begin
            nextCycle();
            memReqReady = 1'b0;
            #1;
            checkOutput($sformatf("toWait%0d", c), {busy, rspValid}, 5'b10000);
        end
        nextCycle();
        #1;
        checkOutput("toRspValid", rspValid, 4'b0001);
        checkOutput("toRspErr", rspErr, 1);
        checkOutput("toRspRdata", rspRdata, 0);
        checkOutput("toIdle", busy, 0);
        memRspValid = 1'b1;
        memRspRdata = 32'hCAFE_F00D;
        nextCycle();
        memRspValid = 1'b0;
        #1;
        checkOutput("toLateIgnored", rspValid, 0);
        checkOutput("toLateBusy", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
